dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the CPU's MEM-stage load/store interface.
- Accepts one word request at a time, completes it after a fixed LATENCY, and returns read data with a one-cycle ready pulse.
- Drives busy_o combinationally so the pipeline's hazard logic can freeze PC, IF/ID, ID/EX and EX/MEM while an access is outstanding.
- Sits beside the EX/MEM register; its rdata_o feeds the MEM/WB register.

Parameters:
- DEPTH, 128, number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 2, cycles from accept edge to completion edge; legal range 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- req_i  input  1  access request; held by the CPU until it sees ready_o.
- we_i  input  1  1 = store, 0 = load; sampled at accept.
- addr_i  input  32  byte address; sampled at accept.
- wdata_i  input  32  store data; sampled at accept.
- rdata_o  output  32  load data; valid while ready_o=1, then held.
- ready_o  output  1  one-cycle completion pulse.
- err_o  output  1  one-cycle error pulse, coincident with ready_o.
- busy_o  output  1  stall request to the hazard unit (combinational).

Behaviour:
- Clock and reset: one clock clk_i; rst_i is asynchronous, active-high.
- Reset values: state=IDLE, count=0, rdata_o=0, ready_o=0, err_o=0, latched request registers=0. Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with req_i=1, latch we/addr/wdata (accept).
  - If addr[1:0]!=0 or addr[31:2]>=DEPTH, mark error and go to RESP on that edge. LATENCY is ignored for errors.
  - Otherwise, if LATENCY=1, perform the access on that edge and go to RESP.
  - Otherwise load count=LATENCY-1 and go to WAIT.
- WAIT: decrement count each edge. On the edge where count==1, perform the access and go to RESP.
- Access rules:
  - Store: mem[addr[31:2]] <= wdata.
  - Load: rdata_o <= mem[addr[31:2]].
  - Error: no memory write; rdata_o <= 0.
- RESP: ready_o=1 (err_o=1 if error) for exactly this one cycle. Next edge returns to IDLE unconditionally.
  - req_i is ignored in RESP; this prevents re-accepting the request that just completed.
- Timing: ready_o rises exactly LATENCY cycles after the accept edge; the error path always takes 1 cycle.
- busy_o = (state==IDLE && req_i) || state==WAIT.
  - busy_o is 0 in RESP, so the pipeline advances on the same edge that MEM/WB captures rdata_o.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after RESP. Minimum throughput is one access per LATENCY+1 cycles.
- Mid-operation changes to req_i, we_i, addr_i or wdata_i after accept: ignored, because the latched copies are used.
- Reset during WAIT or RESP: return to IDLE immediately; a pending store is dropped (memory unchanged); ready_o and err_o are forced to 0 without waiting for the clock.
- rdata_o holds its last value until the next completed load or error.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- Defined: adds port be_i (input, 4 bits), latched at accept. A store writes only the bytes whose be bit is 1 (be[0] = bits 7:0). be=4'b0000 on a store completes normally with no write. Loads ignore be and return the full word.
- Undefined: no be_i port; every store writes all 4 bytes.

Test Plan:
- LATENCY=2, store addr=0x10, wdata=0xDEADBEEF, then load 0x10 -> each access: busy_o=1 for 2 cycles, then ready_o for 1 cycle; load returns rdata_o=0xDEADBEEF; err_o=0.
- LATENCY=1, load addr=0x0 after store 0x12345678 to 0x0 -> ready_o 1 cycle after accept, rdata_o=0x12345678; busy_o high only in the accept cycle.
- Misaligned load addr=0x13, then out-of-range load addr=DEPTH*4 -> each: ready_o=1 and err_o=1 one cycle after accept, rdata_o=0; memory unchanged on readback.
- req_i held high through RESP -> exactly one ready_o pulse; the request is re-accepted only in the following IDLE cycle (two pulses total, LATENCY+1 cycles apart).
- Assert rst_i in WAIT of a store of 0xAAAAAAAA to 0x20 (old value 0x11111111) -> state IDLE, ready_o=0 immediately; later load of 0x20 returns 0x11111111.
- DMEM_BYTE_EN: store 0xFFFFFFFF with be=4'b0101 over 0x00000000 -> load returns 0x00FF00FF.

Source files
------------

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_responder
//   Target end of the MEM-stage load/store interface. It accepts one word
//   request at a time and completes it after a fixed LATENCY. Read data comes
//   back with a one-cycle ready pulse. busy_o is combinational so the hazard
//   unit can freeze the front of the pipeline while an access is outstanding.
//
// Parameters
//   DEPTH    number of 32-bit words (legal word index 0..DEPTH-1)
//   LATENCY  cycles from the accept cycle to the ready pulse (1..15)
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    asynchronous reset, active-high
//   req_i    access request, held by the CPU until it sees ready_o
//   we_i     1 = store, 0 = load (sampled at accept)
//   addr_i   byte address (sampled at accept)
//   wdata_i  store data (sampled at accept)
//   be_i     byte enables, be_i[0] -> bits 7:0 (only with DMEM_BYTE_EN)
//   rdata_o  load data, valid with ready_o, then held
//   ready_o  one-cycle completion pulse
//   err_o    one-cycle error pulse, coincident with ready_o
//   busy_o   stall request to the hazard unit
//
// Build option
//   DMEM_BYTE_EN  adds be_i; stores write only the enabled bytes.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  be_i,
`endif
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic               we_q, err_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [31:0]        mem_q [DEPTH];

  logic               accept;
  logic               do_access;
  logic               bad_addr;

  // Operands of the access. With LATENCY=1 and on the error path the access
  // happens on the accept edge itself, so the live inputs are used there.
  // Otherwise the copies latched at accept are used.
  logic               acc_we, acc_err;
  logic [IDX_W-1:0]   acc_idx;
  logic [31:0]        acc_wdata;
  logic [31:0]        wmask;

  assign bad_addr = (addr_i[1:0] != 2'b00) ||
                    ({2'b00, addr_i[31:2]} >= 32'(DEPTH));

  assign acc_we    = (state_q == S_IDLE) ? we_i                : we_q;
  assign acc_err   = (state_q == S_IDLE) ? bad_addr            : err_q;
  assign acc_idx   = (state_q == S_IDLE) ? addr_i[IDX_W+1:2]   : idx_q;
  assign acc_wdata = (state_q == S_IDLE) ? wdata_i             : wdata_q;

`ifdef DMEM_BYTE_EN
  logic [3:0] be_q, acc_be;
  assign acc_be = (state_q == S_IDLE) ? be_i : be_q;
  always_comb begin
    for (int b = 0; b < 4; b++) wmask[8*b +: 8] = {8{acc_be[b]}};
  end
`else
  assign wmask = '1;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (bad_addr || LATENCY == 1) begin
            do_access = 1'b1;
            state_d   = S_RESP;
          end else begin
            count_d = 4'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;   // req_i ignored: no re-accept of the same request
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        we_q    <= we_i;
        err_q   <= bad_addr;
        idx_q   <= addr_i[IDX_W+1:2];
        wdata_q <= wdata_i;
      end
      if (do_access) begin
        if (acc_err)      rdata_q <= '0;
        else if (!acc_we) rdata_q <= mem_q[acc_idx];
      end
    end
  end

`ifdef DMEM_BYTE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       be_q <= '0;
    else if (accept) be_q <= be_i;
  end
`endif

  // NOTE: the array has no reset so it maps onto RAM. The write is gated with
  // rst_i so that an access that is pending while reset is asserted is dropped.
  always_ff @(posedge clk_i) begin
    if (do_access && acc_we && !acc_err && !rst_i) begin
      mem_q[acc_idx] <= (mem_q[acc_idx] & ~wmask) | (acc_wdata & wmask);
    end
  end

  // The outputs decode the state, so an asynchronous reset clears them at once.
  assign ready_o = (state_q == S_RESP);
  assign err_o   = (state_q == S_RESP) && err_q;
  assign busy_o  = ((state_q == S_IDLE) && req_i) || (state_q == S_WAIT);
  assign rdata_o = rdata_q;

endmodule
